// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter from four byte requesters.
// It supports a burst allowance per grantee and a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter #(
    parameter int p_max_burst    = 1,
    parameter int p_busy_timeout = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        arb_en_i,
    input  logic [3:0]  req_valid_i,
    input  logic [31:0] req_data_i,
    input  logic [11:0] req_cfg_i,
    output logic [3:0]  req_ready_o,
    output logic        tx_enable_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_parity_en_o,
    output logic        tx_parity_sel_o,
    output logic        tx_stop_sel_o,
    input  logic        tx_busy_i,
    output logic        grant_valid_o,
    output logic [1:0]  grant_id_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_last_grant;
    logic [3:0]  r_burst_cnt;
    logic [3:0]  r_busy_cnt;
    logic [1:0]  r_grant_id;
    logic        r_grant_valid;
    logic [7:0]  r_tx_data;
    logic        r_parity_en;
    logic        r_parity_sel;
    logic        r_stop_sel;
    logic        r_err;

    logic        w_keep;
    logic [1:0]  w_cand;
    logic [1:0]  w_rr_id;
    logic [1:0]  w_sel_id;
    logic        w_grant;
    logic        w_timeout;
    logic        w_done;
    logic [2:0]  w_sel_cfg;

    // A zero burst count means there is no previous grantee (post-reset), so requester 0 wins.
    always_comb begin
        w_keep  = (r_burst_cnt != 4'd0) && (r_burst_cnt < 4'(p_max_burst))
                  && req_valid_i[r_last_grant];
        w_rr_id = r_last_grant;
        w_cand  = r_last_grant;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last_grant + 2'(k);
            if (req_valid_i[w_cand]) begin
                w_rr_id = w_cand;
            end
        end
        w_sel_id  = w_keep ? r_last_grant : w_rr_id;
        w_sel_cfg = req_cfg_i[int'(w_sel_id) * 3 +: 3];
        w_grant   = (r_state == S_IDLE) && arb_en_i && (req_valid_i != 4'b0000);
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    w_next_state = S_WAIT_DONE;
                end else if (r_busy_cnt == 4'(p_busy_timeout - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_grant  <= 2'd3;
            r_burst_cnt   <= 4'd0;
            r_grant_id    <= 2'd0;
            r_grant_valid <= 1'b0;
            r_tx_data     <= 8'h00;
            r_parity_en   <= 1'b0;
            r_parity_sel  <= 1'b0;
            r_stop_sel    <= 1'b0;
        end else if (w_grant) begin
            r_last_grant  <= w_sel_id;
            r_burst_cnt   <= w_keep ? r_burst_cnt + 4'd1 : 4'd1;
            r_grant_id    <= w_sel_id;
            r_grant_valid <= 1'b1;
            r_tx_data     <= req_data_i[{w_sel_id, 3'b000} +: 8];
            r_parity_en   <= w_sel_cfg[0];
            r_parity_sel  <= w_sel_cfg[1];
            r_stop_sel    <= w_sel_cfg[2];
        end else if (w_timeout || w_done) begin
            r_grant_valid <= 1'b0;
        end
    end

    // Counts consecutive idle-busy cycles while waiting for the transmitter to start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy_cnt <= 4'd0;
        end else if ((r_state == S_WAIT_BUSY) && !tx_busy_i) begin
            r_busy_cnt <= r_busy_cnt + 4'd1;
        end else begin
            r_busy_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign tx_enable_o     = (r_state == S_LAUNCH);
    assign req_ready_o     = (r_state == S_LAUNCH) ? (4'b0001 << r_grant_id) : 4'b0000;
    assign tx_data_o       = r_tx_data;
    assign tx_parity_en_o  = r_parity_en;
    assign tx_parity_sel_o = r_parity_sel;
    assign tx_stop_sel_o   = r_stop_sel;
    assign grant_valid_o   = r_grant_valid;
    assign grant_id_o      = r_grant_id;
    assign err_o           = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A uses burst 1, instance B burst 2, both on shared stimulus.
module tb_uart_tx_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        arbEn = 1'b0;
    logic [3:0]  reqValid = 4'b0;
    logic [31:0] reqData = 32'b0;
    logic [11:0] reqCfg = 12'b0;
    logic        txBusy = 1'b0;
    logic        errClr = 1'b0;

    logic [3:0]  readyA, readyB;
    logic        txEnA, txEnB;
    logic [7:0]  dataA, dataB;
    logic        penA, pselA, stopA, penB, pselB, stopB;
    logic        gvA, gvB;
    logic [1:0]  idA, idB;
    logic        errA, errB;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.p_max_burst(1), .p_busy_timeout(TIMEOUT)) dutA (
        .clk_i(clk), .rst_n_i(rstN), .arb_en_i(arbEn), .req_valid_i(reqValid),
        .req_data_i(reqData), .req_cfg_i(reqCfg), .req_ready_o(readyA),
        .tx_enable_o(txEnA), .tx_data_o(dataA), .tx_parity_en_o(penA),
        .tx_parity_sel_o(pselA), .tx_stop_sel_o(stopA), .tx_busy_i(txBusy),
        .grant_valid_o(gvA), .grant_id_o(idA), .err_o(errA), .err_clr_i(errClr)
    );

    uart_tx_arbiter #(.p_max_burst(2), .p_busy_timeout(TIMEOUT)) dutB (
        .clk_i(clk), .rst_n_i(rstN), .arb_en_i(arbEn), .req_valid_i(reqValid),
        .req_data_i(reqData), .req_cfg_i(reqCfg), .req_ready_o(readyB),
        .tx_enable_o(txEnB), .tx_data_o(dataB), .tx_parity_en_o(penB),
        .tx_parity_sel_o(pselB), .tx_stop_sel_o(stopB), .tx_busy_i(txBusy),
        .grant_valid_o(gvB), .grant_id_o(idB), .err_o(errB), .err_clr_i(errClr)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic [11:0] cfg, input logic en);
        reqValid = valid;
        reqData  = data;
        reqCfg   = cfg;
        arbEn    = en;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        txBusy = 1'b0;
        errClr = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Starts at a negedge in IDLE; waits for the launch, checks it, then runs the busy handshake.
    task automatic doFrame(input logic [1:0] expA, input logic [1:0] expB, input int maxWait,
                           input bit dropEn, input bit dropValid, input string tag);
        logic       seen;
        logic [2:0] cfgA;
        seen = 1'b0;
        for (int i = 0; i < maxWait && !seen; i++) begin
            @(negedge clk);
            seen = txEnA;
        end
        checkOutput({tag, "_launch"}, 32'(seen), 32'd1);
        cfgA = reqCfg[int'(expA) * 3 +: 3];
        checkOutput({tag, "_idA"}, 32'(idA), 32'(expA));
        checkOutput({tag, "_idB"}, 32'(idB), 32'(expB));
        checkOutput({tag, "_readyA"}, 32'(readyA), 32'(4'b0001 << expA));
        checkOutput({tag, "_dataA"}, 32'(dataA), 32'(reqData[{expA, 3'b000} +: 8]));
        checkOutput({tag, "_cfgA"}, 32'({stopA, pselA, penA}), 32'(cfgA));
        if (dropEn) arbEn = 1'b0;
        if (dropValid) reqValid = 4'b0000;
        txBusy = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_busyEn"}, 32'({txEnA, readyA}), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_doneGv"}, 32'({gvA, txEnA, readyA}), 32'b100000);
        checkOutput({tag, "_holdData"}, 32'(dataA), 32'(reqData[{expA, 3'b000} +: 8]));
        txBusy = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idleGv"}, 32'(gvA), 32'd0);
    endtask

    task automatic waitLaunch(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = txEnA;
        end
        checkOutput({tag, "_launch"}, 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset values
        #2;
        checkOutput("rst_txen", 32'({txEnA, readyA}), 32'd0);
        checkOutput("rst_data", 32'({dataA, stopA, pselA, penA}), 32'd0);
        checkOutput("rst_grant", 32'({gvA, idA, errA}), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Single request, byte 0xA5 with cfg 011
        applyStimulus(4'b0001, 32'h000000A5, 12'b000_000_000_011, 1'b1);
        doFrame(2'd0, 2'd0, 1, 1'b0, 1'b1, "single");
        checkOutput("single_pen", 32'({stopA, pselA, penA}), 32'b011);
        checkOutput("single_held", 32'(dataA), 32'hA5);
        repeat (2) @(negedge clk);
        checkOutput("single_noRelaunch", 32'(txEnA), 32'd0);

        // Round-robin with all four requesters held
        doReset();
        applyStimulus(4'b1111, 32'h44332211, 12'b100_011_010_001, 1'b1);
        doFrame(2'd0, 2'd0, 8, 1'b0, 1'b0, "rr0");
        doFrame(2'd1, 2'd0, 8, 1'b0, 1'b0, "rr1");
        doFrame(2'd2, 2'd1, 8, 1'b0, 1'b0, "rr2");
        doFrame(2'd3, 2'd1, 8, 1'b0, 1'b0, "rr3");
        doFrame(2'd0, 2'd2, 8, 1'b0, 1'b1, "rr4");

        // Burst with requesters 0 and 1 held
        doReset();
        applyStimulus(4'b0011, 32'h44332211, 12'b100_011_010_001, 1'b1);
        doFrame(2'd0, 2'd0, 8, 1'b0, 1'b0, "burst0");
        doFrame(2'd1, 2'd0, 8, 1'b0, 1'b0, "burst1");
        doFrame(2'd0, 2'd1, 8, 1'b0, 1'b0, "burst2");
        doFrame(2'd1, 2'd1, 8, 1'b0, 1'b0, "burst3");
        doFrame(2'd0, 2'd0, 8, 1'b0, 1'b1, "burst4");

        // Busy timeout, sticky error, then clear
        doReset();
        applyStimulus(4'b0001, 32'h0000005A, 12'b0, 1'b1);
        waitLaunch("to1");
        reqValid = 4'b0000;
        repeat (TIMEOUT) @(negedge clk);
        checkOutput("to1_errEarly", 32'(errA), 32'd0);
        @(negedge clk);
        checkOutput("to1_errSet", 32'({errA, errB}), 32'b11);
        checkOutput("to1_gv", 32'({gvA, txEnA}), 32'd0);
        @(negedge clk);
        checkOutput("to1_sticky", 32'(errA), 32'd1);
        errClr = 1'b1;
        @(negedge clk);
        checkOutput("to1_cleared", 32'(errA), 32'd0);

        // Timeout while clear is held: set wins, clear acts on the next edge
        reqValid = 4'b0001;
        waitLaunch("to2");
        reqValid = 4'b0000;
        repeat (TIMEOUT) @(negedge clk);
        checkOutput("to2_errEarly", 32'(errA), 32'd0);
        @(negedge clk);
        checkOutput("to2_setWins", 32'(errA), 32'd1);
        @(negedge clk);
        checkOutput("to2_clrAfter", 32'(errA), 32'd0);
        errClr = 1'b0;

        // Reset asserted during WAIT_DONE, then requester 3 alone
        applyStimulus(4'b0001, 32'h7F0000C3, 12'b101_000_000_111, 1'b1);
        waitLaunch("midrst");
        reqValid = 4'b0000;
        txBusy = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_inFrame", 32'({gvA, dataA}), 32'h1C3);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midrst_en", 32'({txEnA, readyA, gvA, idA, errA}), 32'd0);
        checkOutput("midrst_data", 32'({dataA, stopA, pselA, penA}), 32'd0);
        txBusy = 1'b0;
        reqValid = 4'b1000;
        @(negedge clk);
        rstN = 1'b1;
        doFrame(2'd3, 2'd3, 1, 1'b0, 1'b1, "midrst_req3");

        // Arbitration disabled, then enabled; enable dropped mid-frame
        doReset();
        applyStimulus(4'b0100, 32'h00960000, 12'b000_110_000_000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("dis_noEn", 32'(txEnA), 32'd0);
        end
        arbEn = 1'b1;
        doFrame(2'd2, 2'd2, 1, 1'b1, 1'b0, "en");
        repeat (2) @(negedge clk);
        checkOutput("en_heldOff", 32'({txEnA, gvA}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
